// File: rtl/sys_pkg.sv
// Shared constants for the system-op execute unit: CSR addresses, trap causes,
// mstatus bit positions and the redirect FSM state type.
package sys_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [3:0] MCAUSE_ECALL_M   = 4'd11;
  localparam logic [3:0] MCAUSE_BREAK     = 4'd3;
  localparam logic [3:0] MCAUSE_IRQ_TIMER = 4'd7;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } sys_state_e;

endpackage

// File: rtl/sys_ops.sv
// Decode-to-execute handshake payload for system ops: op bits plus CSR address.
interface sys_ops;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        csrrw;
  logic        csrrs;
  logic        csrrc;
  logic [11:0] csr_addr;

  modport src (output ecall, ebreak, mret, csrrw, csrrs, csrrc, csr_addr);
  modport dst (input  ecall, ebreak, mret, csrrw, csrrs, csrrc, csr_addr);
endinterface

// File: rtl/sys_exec_unit_csr_file.sv
// Machine-mode CSR storage with an address-decoded read mux, one write port,
// and a trap/mret side-effect port that updates mstatus/mepc/mcause.
module csr_file
  import sys_pkg::*;
#(
  parameter int               XLEN      = 64,
  parameter logic [XLEN-1:0]  RESET_VEC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_timer,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            trap_en,
  input  logic [XLEN-1:2] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_en,
  output logic            mstatus_mie,
  output logic            mie_mtie,
  output logic [XLEN-1:0] mtvec_base,
  output logic [XLEN-1:0] mepc_val
);

  logic            mie_reg;
  logic            mpie_reg;
  logic            mtie_reg;
  logic [XLEN-1:2] mtvec_reg;
  logic [XLEN-1:0] mscratch_reg;
  logic [XLEN-1:2] mepc_reg;
  logic [XLEN-1:0] mcause_reg;

  assign mstatus_mie = mie_reg;
  assign mie_mtie    = mtie_reg;
  assign mtvec_base  = {mtvec_reg, 2'b00};
  assign mepc_val    = {mepc_reg, 2'b00};

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CSR_MSTATUS: begin
        rd_data[12:11]            = 2'b11;
        rd_data[MSTATUS_MPIE_BIT] = mpie_reg;
        rd_data[MSTATUS_MIE_BIT]  = mie_reg;
      end
      CSR_MIE:      rd_data[MIE_MTIE_BIT] = mtie_reg;
      CSR_MTVEC:    rd_data = {mtvec_reg, 2'b00};
      CSR_MSCRATCH: rd_data = mscratch_reg;
      CSR_MEPC:     rd_data = {mepc_reg, 2'b00};
      CSR_MCAUSE:   rd_data = mcause_reg;
      CSR_MIP:      rd_data[MIP_MTIP_BIT] = irq_timer;
      default:      rd_data = '0;
    endcase
  end

  // Trap, mret and CSR write are mutually exclusive by construction upstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_reg      <= 1'b0;
      mpie_reg     <= 1'b0;
      mtie_reg     <= 1'b0;
      mtvec_reg    <= RESET_VEC[XLEN-1:2];
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (trap_en) begin
      mepc_reg   <= trap_pc;
      mcause_reg <= trap_cause;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
    end else if (mret_en) begin
      mie_reg  <= mpie_reg;
      mpie_reg <= 1'b1;
    end else if (wr_en) begin
      case (wr_addr)
        CSR_MSTATUS: begin
          mie_reg  <= wr_data[MSTATUS_MIE_BIT];
          mpie_reg <= wr_data[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mtie_reg     <= wr_data[MIE_MTIE_BIT];
        CSR_MTVEC:    mtvec_reg    <= wr_data[XLEN-1:2];
        CSR_MSCRATCH: mscratch_reg <= wr_data;
        CSR_MEPC:     mepc_reg     <= wr_data[XLEN-1:2];
        CSR_MCAUSE:   mcause_reg   <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sys_exec_unit.sv
// Execute-stage system-op unit: CSR read/modify/write, ecall/ebreak/mret and
// timer-interrupt sequencing into a one-cycle fetch redirect.
module sys_exec_unit
  import sys_pkg::*;
#(
  parameter int               XLEN      = 64,
  parameter logic [XLEN-1:0]  RESET_VEC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  sys_ops.dst             sys,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [XLEN-1:0] op_pc,
  input  logic [XLEN-1:0] op_src,
  input  logic            irq_timer,
  input  logic [XLEN-1:0] irq_pc,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  sys_state_e      state_reg;
  logic            rd_valid_reg;
  logic [XLEN-1:0] rd_data_reg;
  logic            redirect_valid_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  logic            mstatus_mie, mie_mtie;
  logic [XLEN-1:0] mtvec_base, mepc_val, csr_old, csr_new, trap_cause;
  logic            irq_take, accept;
  logic            is_ecall, is_ebreak, is_mret, is_rw, is_rs, is_rc, is_csr;
  logic            csr_wr, trap_en, mret_en;

  assign irq_take = (state_reg == IDLE) & irq_timer & mstatus_mie & mie_mtie;
  assign op_ready = (state_reg == IDLE) & ~irq_take;
  assign accept   = op_valid & op_ready;

  // Fixed priority decode: ecall > ebreak > mret > csrrw > csrrs > csrrc.
  assign is_ecall  = sys.ecall;
  assign is_ebreak = ~sys.ecall & sys.ebreak;
  assign is_mret   = ~sys.ecall & ~sys.ebreak & sys.mret;
  assign is_rw     = ~sys.ecall & ~sys.ebreak & ~sys.mret & sys.csrrw;
  assign is_rs     = ~sys.ecall & ~sys.ebreak & ~sys.mret & ~sys.csrrw & sys.csrrs;
  assign is_rc     = ~sys.ecall & ~sys.ebreak & ~sys.mret & ~sys.csrrw & ~sys.csrrs & sys.csrrc;
  assign is_csr    = is_rw | is_rs | is_rc;

  always_comb begin
    csr_new = csr_old & ~op_src;
    if (is_rw)      csr_new = op_src;
    else if (is_rs) csr_new = csr_old | op_src;
  end

  // Set/clear with a zero mask must not write (avoids side effects on read-only use).
  assign csr_wr  = accept & (is_rw | ((is_rs | is_rc) & (|op_src)));
  assign trap_en = irq_take | (accept & (is_ecall | is_ebreak));
  assign mret_en = accept & is_mret;

  always_comb begin
    trap_cause = XLEN'(MCAUSE_BREAK);
    if (irq_take)      trap_cause = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(MCAUSE_IRQ_TIMER);
    else if (is_ecall) trap_cause = XLEN'(MCAUSE_ECALL_M);
  end

  csr_file #(
    .XLEN      (XLEN),
    .RESET_VEC (RESET_VEC)
  ) u_csr_file (
    .clk         (clk),
    .rst         (rst),
    .irq_timer   (irq_timer),
    .rd_addr     (sys.csr_addr),
    .rd_data     (csr_old),
    .wr_en       (csr_wr),
    .wr_addr     (sys.csr_addr),
    .wr_data     (csr_new),
    .trap_en     (trap_en),
    .trap_pc     (irq_take ? irq_pc[XLEN-1:2] : op_pc[XLEN-1:2]),
    .trap_cause  (trap_cause),
    .mret_en     (mret_en),
    .mstatus_mie (mstatus_mie),
    .mie_mtie    (mie_mtie),
    .mtvec_base  (mtvec_base),
    .mepc_val    (mepc_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      rd_valid_reg       <= 1'b0;
      rd_data_reg        <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      rd_valid_reg       <= 1'b0;
      redirect_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trap_en) begin
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= mtvec_base;
            state_reg          <= REDIR;
          end else if (mret_en) begin
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= mepc_val;
            state_reg          <= REDIR;
          end
          if (accept & is_csr) begin
            rd_valid_reg <= 1'b1;
            rd_data_reg  <= csr_old;
          end
        end
        REDIR:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rd_valid       = rd_valid_reg;
  assign rd_data        = rd_data_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_sys_exec_unit.sv
// Directed self-checking bench for sys_exec_unit: CSR ops, traps, mret,
// timer interrupt priority and asynchronous reset during a redirect.
module tb_sys_exec_unit;
  import sys_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [XLEN-1:0] op_pc = '0;
  logic [XLEN-1:0] op_src = '0;
  logic            irq_timer = 1'b0;
  logic [XLEN-1:0] irq_pc = '0;
  logic            rd_valid;
  logic [XLEN-1:0] rd_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int n_assert = 0;
  int n_fail   = 0;

  sys_ops sys_if ();

  sys_exec_unit #(.XLEN(XLEN), .RESET_VEC(64'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .sys            (sys_if),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_pc          (op_pc),
    .op_src         (op_src),
    .irq_timer      (irq_timer),
    .irq_pc         (irq_pc),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-22s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_bits(input logic [5:0] b, input logic [11:0] addr);
    {sys_if.ecall, sys_if.ebreak, sys_if.mret, sys_if.csrrw, sys_if.csrrs, sys_if.csrrc} = b;
    sys_if.csr_addr = addr;
  endtask

  // Drive one op for one cycle; outputs are sampled 1 time unit after the accept edge.
  task automatic do_op(input logic [5:0] b, input logic [11:0] addr,
                       input logic [XLEN-1:0] src, input logic [XLEN-1:0] pc);
    @(negedge clk);
    set_bits(b, addr);
    op_src   = src;
    op_pc    = pc;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    set_bits(6'b0, 12'h000);
  endtask

  localparam logic [5:0] OP_ECALL = 6'b100000;
  localparam logic [5:0] OP_EBRK  = 6'b010000;
  localparam logic [5:0] OP_MRET  = 6'b001000;
  localparam logic [5:0] OP_RW    = 6'b000100;
  localparam logic [5:0] OP_RS    = 6'b000010;
  localparam logic [5:0] OP_RC    = 6'b000001;

  task automatic csr_op(input string tag, input logic [5:0] b, input logic [11:0] addr,
                        input logic [XLEN-1:0] src, input logic [XLEN-1:0] exp_old);
    do_op(b, addr, src, '0);
    check({tag, ".vld"}, {63'b0, rd_valid}, 64'd1);
    check({tag, ".old"}, rd_data, exp_old);
  endtask

  task automatic read_csr(input string tag, input logic [11:0] addr, input logic [XLEN-1:0] exp);
    csr_op(tag, OP_RS, addr, '0, exp);
  endtask

  // After a trap/mret accept edge: one REDIR cycle, then back to IDLE.
  task automatic check_redirect(input string tag, input logic [XLEN-1:0] exp_pc);
    check({tag, ".rv"},    {63'b0, redirect_valid}, 64'd1);
    check({tag, ".rpc"},   redirect_pc, exp_pc);
    check({tag, ".rdy0"},  {63'b0, op_ready}, 64'd0);
    @(posedge clk);
    #1;
    check({tag, ".rv0"},   {63'b0, redirect_valid}, 64'd0);
    check({tag, ".hold"},  redirect_pc, exp_pc);
    check({tag, ".rdy1"},  {63'b0, op_ready}, 64'd1);
  endtask

  initial begin
    set_bits(6'b0, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // 1. reset state
    check("rst.op_ready", {63'b0, op_ready}, 64'd1);
    check("rst.redir_v",  {63'b0, redirect_valid}, 64'd0);
    check("rst.redir_pc", redirect_pc, 64'd0);
    check("rst.rd_valid", {63'b0, rd_valid}, 64'd0);
    read_csr("rst.mtvec",   CSR_MTVEC,   64'h8000_0000);
    read_csr("rst.mstatus", CSR_MSTATUS, 64'h1800);

    // 2. mscratch write / set / clear
    csr_op("rw.mscratch", OP_RW, CSR_MSCRATCH, 64'hDEAD, 64'h0);
    csr_op("rs.mscratch", OP_RS, CSR_MSCRATCH, 64'h00F0, 64'hDEAD);
    csr_op("rc.mscratch", OP_RC, CSR_MSCRATCH, 64'h00FD, 64'hDEFD);
    read_csr("mscratch.fin", CSR_MSCRATCH, 64'hDE00);
    // priority: csrrw beats csrrs when both set
    csr_op("prio.rw", OP_RW | OP_RS, CSR_MSCRATCH, 64'h1234, 64'hDE00);
    read_csr("prio.chk", CSR_MSCRATCH, 64'h1234);

    // 3. mtvec written then ecall
    csr_op("rw.mtvec", OP_RW, CSR_MTVEC, 64'h1003, 64'h8000_0000);
    do_op(OP_ECALL | OP_RW, CSR_MSCRATCH, 64'hFFFF, 64'h2000);
    check_redirect("ecall", 64'h1000);
    read_csr("ecall.mepc",    CSR_MEPC,     64'h2000);
    read_csr("ecall.mcause",  CSR_MCAUSE,   64'd11);
    read_csr("ecall.mstatus", CSR_MSTATUS,  64'h1800);
    read_csr("ecall.mscr",    CSR_MSCRATCH, 64'h1234);

    // 4. MIE=1, ebreak, then mret to 0x2000
    csr_op("set.mie", OP_RS, CSR_MSTATUS, 64'h8, 64'h1800);
    do_op(OP_EBRK, 12'h000, '0, 64'h3000);
    check_redirect("ebreak", 64'h1000);
    read_csr("ebrk.mcause",  CSR_MCAUSE,  64'd3);
    read_csr("ebrk.mstatus", CSR_MSTATUS, 64'h1880);
    csr_op("rw.mepc", OP_RW, CSR_MEPC, 64'h2002, 64'h3000);
    do_op(OP_MRET, 12'h000, '0, '0);
    check_redirect("mret", 64'h2000);
    read_csr("mret.mstatus", CSR_MSTATUS, 64'h1888);

    // 5. timer interrupt beats a simultaneous csrrw
    csr_op("rw.mie", OP_RW, CSR_MIE, 64'h80, 64'h0);
    read_csr("mip.low", CSR_MIP, 64'h0);
    @(negedge clk);
    irq_timer = 1'b1;
    irq_pc    = 64'h4004;
    set_bits(OP_RW, CSR_MSCRATCH);
    op_src   = 64'h55;
    op_valid = 1'b1;
    #1;
    check("irq.rdy0", {63'b0, op_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("irq.rv",      {63'b0, redirect_valid}, 64'd1);
    check("irq.rpc",     redirect_pc, 64'h1000);
    check("irq.no_rd",   {63'b0, rd_valid}, 64'd0);
    check("irq.rdy_r",   {63'b0, op_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("irq.rv0",     {63'b0, redirect_valid}, 64'd0);
    check("irq.rdy1",    {63'b0, op_ready}, 64'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    set_bits(6'b0, 12'h000);
    check("irq.op.vld",  {63'b0, rd_valid}, 64'd1);
    check("irq.op.old",  rd_data, 64'h1234);
    read_csr("irq.mcause",  CSR_MCAUSE,   64'h8000_0000_0000_0007);
    read_csr("irq.mepc",    CSR_MEPC,     64'h4004);
    read_csr("irq.mstatus", CSR_MSTATUS,  64'h1880);
    read_csr("irq.mip",     CSR_MIP,      64'h80);
    read_csr("irq.mscr",    CSR_MSCRATCH, 64'h55);
    irq_timer = 1'b0;

    // unimplemented CSR: reads zero, write dropped
    csr_op("unimp.rw", OP_RW, 12'h7C0, 64'h1234, 64'h0);
    read_csr("unimp.rd",   12'h7C0,      64'h0);
    read_csr("unimp.mscr", CSR_MSCRATCH, 64'h55);

    // 6. reset asserted during REDIR
    do_op(OP_ECALL, 12'h000, '0, 64'h5000);
    check("rr.rv", {63'b0, redirect_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("rr.rv0",   {63'b0, redirect_valid}, 64'd0);
    check("rr.rpc0",  redirect_pc, 64'd0);
    check("rr.rdy",   {63'b0, op_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    read_csr("rr.mtvec",   CSR_MTVEC,    64'h8000_0000);
    read_csr("rr.mstatus", CSR_MSTATUS,  64'h1800);
    read_csr("rr.mscr",    CSR_MSCRATCH, 64'h0);
    read_csr("rr.mepc",    CSR_MEPC,     64'h0);
    read_csr("rr.mie",     CSR_MIE,      64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
